// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: enb encodings, fetch FSM states, fetch queue
// entry layout and instruction field positions.
package pipe_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] ENB_FLUSH = 2'b00;
   localparam logic [1:0] ENB_RUN   = 2'b01;
   localparam logic [1:0] ENB_STALL = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } fetch_state_t;

   localparam int OPCODE_LSB = 2;
   localparam int OPCODE_MSB = 6;
   localparam int RD_LSB     = 7;
   localparam int RD_MSB     = 11;
   localparam int FUNC3_LSB  = 12;
   localparam int FUNC3_MSB  = 14;
   localparam int RS1_LSB    = 15;
   localparam int RS1_MSB    = 19;
   localparam int RS2_LSB    = 20;
   localparam int RS2_MSB    = 24;
   localparam int FUNC7_LSB  = 25;
   localparam int FUNC7_MSB  = 31;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   // Fetch addresses are always word aligned; the low two bits are dropped.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry FIFO of {pc, instruction} pairs; slot0 is always the head so the
// presented instruction comes straight from a register.
module fetch_queue
   import pipe_pkg::*;
(
   input  logic            cpu_clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  logic [XLEN-1:0] push_pc,
   input  logic [XLEN-1:0] push_inst,
   output logic [XLEN-1:0] head_pc,
   output logic [XLEN-1:0] head_inst,
   output logic            empty,
   output logic [1:0]      occupancy
);

   fetch_entry_t slot0_q;
   fetch_entry_t slot1_q;
   fetch_entry_t in_entry;
   logic [1:0]   occ_q;
   logic         do_push;
   logic         do_pop;

   assign in_entry = {push_pc, push_inst};
   assign do_pop   = pop && (occ_q != 2'd0);
   assign do_push  = push && ((occ_q != 2'd2) || do_pop);

   // A pop shifts slot1 into slot0; a push lands in the first free slot.
   always_ff @(posedge cpu_clk or negedge reset) begin
      if (!reset) begin
         slot0_q <= '0;
         slot1_q <= '0;
         occ_q   <= 2'd0;
      end else if (flush) begin
         occ_q <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b01: begin
               slot0_q <= slot1_q;
               occ_q   <= occ_q - 2'd1;
            end
            2'b10: begin
               if (occ_q == 2'd0) begin
                  slot0_q <= in_entry;
               end else begin
                  slot1_q <= in_entry;
               end
               occ_q <= occ_q + 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  slot0_q <= in_entry;
               end else begin
                  slot0_q <= slot1_q;
                  slot1_q <= in_entry;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign head_pc   = slot0_q.pc;
   assign head_inst = slot0_q.inst;
   assign empty     = (occ_q == 2'd0);
   assign occupancy = occ_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Pipeline front end: PC sequencing, single-outstanding instruction memory
// requests, a two-entry fetch queue and decode field slicing of its head.
module instr_fetch_unit
   import pipe_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              PC_STEP  = 4
) (
   input  logic            cpu_clk,
   input  logic            reset,
   input  logic            stall_req,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [1:0]      enb,
   output logic [XLEN-1:0] count,
   output logic [XLEN-1:0] instt,
   output logic [4:0]      opcode,
   output logic [4:0]      rd,
   output logic [2:0]      func_3,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [6:0]      func_7
);

   localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

   fetch_state_t    state_q;
   fetch_state_t    state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] issue_pc_q;
   logic            issue;
   logic            push;
   logic            pop;
   logic            rv_done;
   logic            outstanding_left;
   logic [1:0]      next_occ;
   logic            q_empty;
   logic [1:0]      q_occ;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_inst;

   fetch_queue u_queue (
      .cpu_clk   (cpu_clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (redirect_valid),
      .push_pc   (issue_pc_q),
      .push_inst (imem_rdata),
      .head_pc   (head_pc),
      .head_inst (head_inst),
      .empty     (q_empty),
      .occupancy (q_occ)
   );

   // enb priority, credit check and next state. A new request is issued only
   // if the entries left after this edge plus that request fit in the queue.
   always_comb begin
      enb              = ENB_FLUSH;
      state_d          = state_q;
      if (!reset || redirect_valid) begin
         enb = ENB_FLUSH;
      end else if (stall_req) begin
         enb = ENB_STALL;
      end else if (!q_empty) begin
         enb = ENB_RUN;
      end
      pop              = (enb == ENB_RUN);
      rv_done          = imem_rvalid && (state_q != IDLE);
      push             = imem_rvalid && (state_q == WAIT) && !redirect_valid;
      outstanding_left = (state_q != IDLE) && !rv_done;
      next_occ         = q_occ + {1'b0, push} - {1'b0, pop};
      issue            = reset && !redirect_valid && !outstanding_left &&
                         (next_occ < 2'd2);

      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = WAIT;
            end
         end
         WAIT, DROP: begin
            if (redirect_valid) begin
               state_d = rv_done ? IDLE : DROP;
            end else if (rv_done) begin
               state_d = issue ? WAIT : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, fetch PC and the PC of the in-flight request.
   always_ff @(posedge cpu_clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         issue_pc_q <= RESET_PC;
      end else begin
         state_q <= state_d;
         if (redirect_valid) begin
            pc_q <= word_align(redirect_pc);
         end else if (issue) begin
            pc_q       <= pc_q + STEP;
            issue_pc_q <= pc_q;
         end
      end
   end

   assign imem_req  = issue;
   assign imem_addr = pc_q;

   assign count  = q_empty ? '0 : head_pc;
   assign instt  = q_empty ? '0 : head_inst;
   assign opcode = instt[OPCODE_MSB:OPCODE_LSB];
   assign rd     = instt[RD_MSB:RD_LSB];
   assign func_3 = instt[FUNC3_MSB:FUNC3_LSB];
   assign rs1    = instt[RS1_MSB:RS1_LSB];
   assign rs2    = instt[RS2_MSB:RS2_LSB];
   assign func_7 = instt[FUNC7_MSB:FUNC7_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, fixed-latency
// instruction memory model driven one cycle at a time.
module tb_instr_fetch_unit;

   logic        cpu_clk;
   logic        reset;
   logic        stall_req;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [1:0]  enb;
   logic [31:0] count;
   logic [31:0] instt;
   logic [4:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  func_3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  func_7;

   int          checks = 0;
   int          errors = 0;
   int          cyc;
   int          memLat;
   int          memDue;
   logic        memPending;
   logic [31:0] memAddr;

   logic        sReq;
   logic [31:0] sAddr;
   logic [1:0]  sEnb;
   logic [31:0] sCount;
   logic [31:0] sInstt;
   logic [4:0]  sOpcode;
   logic [4:0]  sRd;
   logic [2:0]  sFunc3;
   logic [4:0]  sRs1;
   logic [4:0]  sRs2;
   logic [6:0]  sFunc7;

   instr_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (4)
   ) dut (
      .cpu_clk        (cpu_clk),
      .reset          (reset),
      .stall_req      (stall_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .enb            (enb),
      .count          (count),
      .instt          (instt),
      .opcode         (opcode),
      .rd             (rd),
      .func_3         (func_3),
      .rs1            (rs1),
      .rs2            (rs2),
      .func_7         (func_7)
   );

   initial begin
      cpu_clk = 1'b0;
      forever #5 cpu_clk = ~cpu_clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Memory contents: address 0 holds addi x1,x0,5; others are address tagged.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return {a[23:0], 8'h13};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs (including any due memory response), sample
   // outputs at the falling edge, then advance to just after the next rising edge.
   task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] rpc);
      stall_req      = stall;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (memPending && cyc == memDue) begin
         imem_rvalid = 1'b1;
         imem_rdata  = memWord(memAddr);
         memPending  = 1'b0;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      @(negedge cpu_clk);
      sReq    = imem_req;
      sAddr   = imem_addr;
      sEnb    = enb;
      sCount  = count;
      sInstt  = instt;
      sOpcode = opcode;
      sRd     = rd;
      sFunc3  = func_3;
      sRs1    = rs1;
      sRs2    = rs2;
      sFunc7  = func_7;
      if (sReq) begin
         memPending = 1'b1;
         memAddr    = sAddr;
         memDue     = cyc + memLat;
      end
      @(posedge cpu_clk);
      #1;
      cyc++;
   endtask

   task automatic doReset(input int lat);
      reset          = 1'b0;
      stall_req      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      memPending     = 1'b0;
      memLat         = lat;
      repeat (2) @(posedge cpu_clk);
      #1;
      reset = 1'b1;
      cyc   = 0;
   endtask

   initial begin
      reset          = 1'b0;
      stall_req      = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      memPending     = 1'b0;
      memLat         = 1;
      memDue         = 0;
      memAddr        = 32'h0;
      cyc            = 0;
      #3;
      checkOutput("reset enb", {30'h0, enb}, 32'h0);
      checkOutput("reset req", {31'h0, imem_req}, 32'h0);
      checkOutput("reset count", count, 32'h0);
      checkOutput("reset instt", instt, 32'h0);

      // Test 1: first fetch latency and decode of addi x1,x0,5
      doReset(1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t1 c0 req", {31'h0, sReq}, 32'h1);
      checkOutput("t1 c0 addr", sAddr, 32'h0);
      checkOutput("t1 c0 enb", {30'h0, sEnb}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t1 c1 enb", {30'h0, sEnb}, 32'h0);
      checkOutput("t1 c1 addr", sAddr, 32'h4);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t1 c2 enb", {30'h0, sEnb}, 32'h1);
      checkOutput("t1 c2 count", sCount, 32'h0);
      checkOutput("t1 c2 instt", sInstt, 32'h0050_0093);
      checkOutput("t1 c2 opcode", {27'h0, sOpcode}, 32'h4);
      checkOutput("t1 c2 rd", {27'h0, sRd}, 32'h1);
      checkOutput("t1 c2 rs1", {27'h0, sRs1}, 32'h0);
      checkOutput("t1 c2 rs2", {27'h0, sRs2}, 32'h5);
      checkOutput("t1 c2 func_3", {29'h0, sFunc3}, 32'h0);
      checkOutput("t1 c2 func_7", {25'h0, sFunc7}, 32'h0);
      checkOutput("t1 c2 addr", sAddr, 32'h8);

      // Test 2: sustained one instruction per cycle
      for (int i = 1; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
         checkOutput("t2 enb", {30'h0, sEnb}, 32'h1);
         checkOutput("t2 count", sCount, 32'(4 * i));
         checkOutput("t2 instt", sInstt, memWord(32'(4 * i)));
         checkOutput("t2 req", {31'h0, sReq}, 32'h1);
         checkOutput("t2 addr", sAddr, 32'(4 * (i + 2)));
      end

      // Test 3: stall fills the queue, then drains in order
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         checkOutput("t3 stall enb", {30'h0, sEnb}, 32'h2);
         checkOutput("t3 stall count", sCount, 32'h10);
         checkOutput("t3 stall req", {31'h0, sReq}, 32'h0);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
         checkOutput("t3 drain enb", {30'h0, sEnb}, 32'h1);
         checkOutput("t3 drain count", sCount, 32'(32'h10 + 4 * i));
         checkOutput("t3 drain instt", sInstt, memWord(32'(32'h10 + 4 * i)));
         if (i == 0) begin
            checkOutput("t3 resume req", {31'h0, sReq}, 32'h1);
            checkOutput("t3 resume addr", sAddr, 32'h18);
         end
      end

      // Test 4: redirect while waiting, stale response dropped
      doReset(2);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h0000_0103);
      checkOutput("t4 redirect enb", {30'h0, sEnb}, 32'h0);
      checkOutput("t4 redirect req", {31'h0, sReq}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t4 drop req", {31'h0, sReq}, 32'h1);
      checkOutput("t4 drop addr", sAddr, 32'h100);
      checkOutput("t4 drop enb", {30'h0, sEnb}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t4 no stale enb", {30'h0, sEnb}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t4 target enb", {30'h0, sEnb}, 32'h1);
      checkOutput("t4 target count", sCount, 32'h100);
      checkOutput("t4 target instt", sInstt, memWord(32'h100));

      // Test 5: redirect and response in the same cycle
      doReset(1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h0000_0200);
      checkOutput("t5 redirect enb", {30'h0, sEnb}, 32'h0);
      checkOutput("t5 redirect req", {31'h0, sReq}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t5 next req", {31'h0, sReq}, 32'h1);
      checkOutput("t5 next addr", sAddr, 32'h200);
      checkOutput("t5 discarded enb", {30'h0, sEnb}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t5 target enb", {30'h0, sEnb}, 32'h1);
      checkOutput("t5 target count", sCount, 32'h200);

      // Test 5b: redirect beats stall and flushes a full queue
      doReset(1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("t5b stall enb", {30'h0, sEnb}, 32'h2);
      checkOutput("t5b stall req", {31'h0, sReq}, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h0000_0302);
      checkOutput("t5b priority enb", {30'h0, sEnb}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t5b flushed enb", {30'h0, sEnb}, 32'h0);
      checkOutput("t5b refetch addr", sAddr, 32'h300);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t5b target count", sCount, 32'h300);
      checkOutput("t5b target enb", {30'h0, sEnb}, 32'h1);

      // Test 6: reset asserted while a 3-cycle request is in flight
      doReset(3);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
      end
      stall_req  = 1'b1;
      reset      = 1'b0;
      memPending = 1'b0;
      #2;
      checkOutput("t6 reset enb", {30'h0, enb}, 32'h0);
      checkOutput("t6 reset req", {31'h0, imem_req}, 32'h0);
      checkOutput("t6 reset count", count, 32'h0);
      checkOutput("t6 reset instt", instt, 32'h0);
      doReset(1);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t6 restart req", {31'h0, sReq}, 32'h1);
      checkOutput("t6 restart addr", sAddr, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("t6 restart count", sCount, 32'h0);
      checkOutput("t6 restart instt", sInstt, 32'h0050_0093);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
